// File: rtl/iir_mc_if.sv
// Streaming interface for the multi-channel IIR smoother.
// Input side : valid_i, data_i (signed sample), chan_i, coef_i (Q1.coef_frac_p),
//              clear_i (prime the channel), ready_o (back to the source).
// Output side: valid_o, data_o (signed filtered sample), chan_o,
//              ready_i (from the consumer).
// Modports   : slave  = the filter block, master = the driving/consuming side.
interface iir_mc_if #(
  parameter int width_p     = 10,
  parameter int coef_frac_p = 5,
  parameter int channels_p  = 4
);
  localparam int chan_w = (channels_p > 1) ? $clog2(channels_p) : 1;

  logic                        valid_i;
  logic signed [width_p-1:0]   data_i;
  logic [chan_w-1:0]           chan_i;
  logic [coef_frac_p:0]        coef_i;
  logic                        clear_i;
  logic                        ready_o;
  logic                        valid_o;
  logic signed [width_p-1:0]   data_o;
  logic [chan_w-1:0]           chan_o;
  logic                        ready_i;

  modport slave (
    input  valid_i, data_i, chan_i, coef_i, clear_i, ready_i,
    output ready_o, valid_o, data_o, chan_o
  );

  modport master (
    output valid_i, data_i, chan_i, coef_i, clear_i, ready_i,
    input  ready_o, valid_o, data_o, chan_o
  );
endinterface

// File: rtl/iir_mc.sv
// Multi-channel first-order IIR low-pass (exponential smoother), y += b*(x - y).
// Each of channels_p interleaved channels keeps its own signed state of
// width_p integer + frac_p fractional bits. The coefficient arrives with every
// sample (Q1.coef_frac_p, clamped to 1.0); clear_i loads the state with x.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   io (slave)     : valid/ready input (data_i, chan_i, coef_i, clear_i) and
//                    valid/ready output (data_o, chan_o) through a one-entry
//                    elastic output register; latency 1 cycle, 1 sample/cycle.
module iir_mc #(
  parameter int width_p     = 10,
  parameter int frac_p      = 17,
  parameter int coef_frac_p = 5,
  parameter int channels_p  = 4,
  parameter int round_p     = 0
) (
  input  logic     clk_i,
  input  logic     reset_i,
  iir_mc_if.slave  io
);

  localparam int state_w = width_p + frac_p;
  localparam int diff_w  = width_p + 1 + frac_p;
  localparam int coef_w  = coef_frac_p + 1;
  localparam int prod_w  = diff_w + coef_w + 1;

  localparam logic [coef_w-1:0] unity_c = {1'b1, {coef_frac_p{1'b0}}};
  localparam logic signed [state_w-1:0] half_c =
    {{width_p{1'b0}}, 1'b1, {(frac_p-1){1'b0}}};

  // Coefficients above 1.0 behave as exactly 1.0 (track the input).
  function automatic logic [coef_w-1:0] clamp_coef(input logic [coef_w-1:0] c);
    if (c > unity_c) return unity_c;
    return c;
  endfunction

  // Integer field of the state, optionally rounded half up. The state is a
  // floored convex combination of in-range samples, so adding one half
  // never wraps.
  function automatic logic signed [width_p-1:0] to_out(input logic signed [state_w-1:0] y);
    logic signed [state_w-1:0] t;
    t = (round_p != 0) ? y + half_c : y;
    return width_p'(t >>> frac_p);
  endfunction

  logic signed [state_w-1:0] y_q [channels_p];

  logic                      accept;
  logic signed [state_w-1:0] y_cur;
  logic signed [state_w-1:0] x_ext;
  logic signed [coef_w:0]    b_s;
  logic signed [diff_w-1:0]  diff;
  logic signed [prod_w-1:0]  prod;
  logic signed [state_w-1:0] y_new;

  logic                      vld_p1;
  logic signed [width_p-1:0] data_p1;
  logic [$bits(io.chan_i)-1:0] chan_p1;

  assign io.ready_o = ~vld_p1 | io.ready_i;
  assign accept     = io.valid_i & io.ready_o;

  // ---- stage p0: state update for the accepted channel ----
  always_comb begin
    y_cur = y_q[io.chan_i];
    x_ext = {io.data_i, {frac_p{1'b0}}};
    b_s   = {1'b0, clamp_coef(io.coef_i)};
    diff  = diff_w'(x_ext) - diff_w'(y_cur);
    prod  = prod_w'(diff) * prod_w'(b_s);
    // The true sum always fits state_w, so adding the truncated step in
    // two's complement gives the exact result even when |diff| does not fit.
    if (io.clear_i) y_new = x_ext;
    else            y_new = y_cur + state_w'(prod >>> coef_frac_p);
  end

  // ---- stage p1: channel state and elastic output register ----
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      for (int c = 0; c < channels_p; c++) y_q[c] <= '0;
    end else begin
      if (accept) begin
        y_q[io.chan_i] <= y_new;
        data_p1        <= to_out(y_new);
        chan_p1        <= io.chan_i;
        vld_p1         <= 1'b1;
      end else if (io.ready_i) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign io.valid_o = vld_p1;
  assign io.data_o  = data_p1;
  assign io.chan_o  = chan_p1;

endmodule

// File: tb/tb_iir_mc.sv
// Self-checking bench for iir_mc. Two instances (truncating and rounding
// output) see identical stimulus; a behavioural model holds the exact channel
// states and a queue of expected outputs, and a negedge process checks both
// instances every cycle. Directed sequences pin the model with literal values,
// then a randomized valid/ready phase exercises backpressure and reset.
module tb_iir_mc;
  localparam int W  = 10;
  localparam int F  = 17;
  localparam int CF = 6;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iir_mc_if #(.width_p(W), .coef_frac_p(CF), .channels_p(CH)) ift ();
  iir_mc_if #(.width_p(W), .coef_frac_p(CF), .channels_p(CH)) ifr ();

  iir_mc #(.width_p(W), .frac_p(F), .coef_frac_p(CF), .channels_p(CH), .round_p(0))
    dut_t (.clk_i(clk), .reset_i(rst), .io(ift));
  iir_mc #(.width_p(W), .frac_p(F), .coef_frac_p(CF), .channels_p(CH), .round_p(1))
    dut_r (.clk_i(clk), .reset_i(rst), .io(ifr));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { longint dt; longint dr; longint ch; } exp_t;
  exp_t   q[$];
  longint ym[CH];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact state as an integer scaled by 2^F.
  function automatic longint model_step(input longint y, input int x, input int coef, input bit clr);
    longint xe, d, b;
    xe = longint'(x) * (longint'(1) << F);
    if (clr) return xe;
    b = (coef > (1 << CF)) ? (1 << CF) : coef;
    d = xe - y;
    return y + ((d * b) >>> CF);  // floor of d*b / 2^CF
  endfunction

  function automatic longint out_trunc(input longint y);
    return y >>> F;
  endfunction

  function automatic longint out_round(input longint y);
    return (y + (longint'(1) << (F - 1))) >>> F;
  endfunction

  // ---- per-cycle comparison against the model ----
  always @(negedge clk) begin
    bit exp_ready, acc;
    exp_t e;
    longint yn;
    if (rst) begin
      q.delete();
      for (int c = 0; c < CH; c++) ym[c] = 0;
    end else begin
      exp_ready = (q.size() == 0) || ift.ready_i;
      chk("ready_o_t", ift.ready_o, exp_ready);
      chk("ready_o_r", ifr.ready_o, exp_ready);
      chk("valid_o_t", ift.valid_o, q.size() != 0);
      chk("valid_o_r", ifr.valid_o, q.size() != 0);
      if (q.size() != 0) begin
        chk("data_o_t", ift.data_o, q[0].dt);
        chk("data_o_r", ifr.data_o, q[0].dr);
        chk("chan_o_t", ift.chan_o, q[0].ch);
        chk("chan_o_r", ifr.chan_o, q[0].ch);
        if (ift.ready_i) void'(q.pop_front());
      end
      acc = ift.valid_i && exp_ready;
      if (acc) begin
        yn = model_step(ym[ift.chan_i], int'(ift.data_i), int'(ift.coef_i), ift.clear_i);
        if (yn < -(longint'(512) << F) || yn > (longint'(511) << F)) begin
          n_err++;
          $display("FAIL state_range: got %0d, expected within [%0d,%0d]",
                   yn, -(longint'(512) << F), longint'(511) << F);
        end
        ym[ift.chan_i] = yn;
        e.dt = out_trunc(yn);
        e.dr = out_round(yn);
        e.ch = ift.chan_i;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input bit v, input int ch, input int x, input int coef, input bit clr);
    ift.valid_i = v;  ifr.valid_i = v;
    ift.chan_i  = 2'(ch);  ifr.chan_i = 2'(ch);
    ift.data_i  = 10'(x);  ifr.data_i = 10'(x);
    ift.coef_i  = 7'(coef); ifr.coef_i = 7'(coef);
    ift.clear_i = clr; ifr.clear_i = clr;
  endtask

  task automatic set_rdy(input bit r);
    ift.ready_i = r;
    ifr.ready_i = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_valid_o", ift.valid_o, 0);
    chk("rst_data_o", ift.data_o, 0);
    chk("rst_chan_o", ift.chan_o, 0);
    chk("rst_ready_o", ift.ready_o, 1);
  endtask

  // One accepted sample (ready_i held at 1); returns 1 cycle later, #1 after the edge.
  task automatic send(input int ch, input int x, input int coef, input bit clr,
                      input string nm, input bit ct, input int et, input bit cr, input int er);
    drive(1, ch, x, coef, clr);
    @(posedge clk); #1;
    if (ct) chk({nm, "_t"}, ift.data_o, et);
    if (cr) chk({nm, "_r"}, ifr.data_o, er);
  endtask

  initial begin
    int n;
    drive(0, 0, 0, 0, 0);
    set_rdy(1);
    do_reset();

    // Step response on channel 0.
    send(0, 100, 59, 0, "step1", 1, 92, 1, 92);
    send(0, 100, 59, 0, "step2", 1, 99, 1, 99);
    chk("step2_state", ym[0], 64'sd13027200);
    for (int i = 3; i <= 6; i++) send(0, 100, 59, 0, "step", 0, 0, 0, 0);
    chk("step6_r", ifr.data_o, 100);

    // Interleaved channels with independent state.
    do_reset();
    send(0, 100, 59, 0, "il_c0a", 1, 92, 1, 92);
    send(1, -200, 59, 0, "il_c1a", 1, -185, 1, -184);
    send(0, 100, 59, 0, "il_c0b", 1, 99, 1, 99);
    send(1, -200, 59, 0, "il_c1b", 1, -199, 1, -199);
    chk("il_chan", ift.chan_o, 1);

    // Coefficient clamp and extremes.
    send(3, -512, 127, 0, "clamp_neg", 1, -512, 1, -512);
    send(3, 511, 127, 0, "clamp_pos", 1, 511, 1, 511);
    send(3, 0, 0, 0, "hold_b0", 1, 511, 1, 511);

    // Priming a channel.
    for (int i = 0; i < 3; i++) send(2, 0, 59, 0, "prime_zero", 1, 0, 0, 0);
    send(2, 300, 59, 1, "prime_clr", 1, 300, 1, 300);
    send(2, 300, 32, 0, "prime_next", 1, 300, 1, 300);

    // Rounding versus truncation of a half.
    do_reset();
    send(0, 1, 32, 0, "half", 1, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("drain_valid", ift.valid_o, 0);
    chk("drain_data_hold", ift.data_o, 0);

    // Randomized traffic with backpressure.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        drive(1, 1, 77, 40, 0);
        set_rdy(0);
        @(posedge clk); #1;
        n = 0;
        while (!ift.valid_o && n < 20) begin @(posedge clk); #1; n++; end
        chk("stall_valid", ift.valid_o, 1);
        chk("stall_ready_o", ift.ready_o, 0);
        // Reset during the stall with an accept offered at the same edge.
        rst = 1'b1;
        set_rdy(1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_stall_valid", ift.valid_o, 0);
        chk("rst_stall_data", ift.data_o, 0);
        chk("rst_stall_chan", ift.chan_o, 0);
        send(1, 0, 0, 0, "restart_c1", 1, 0, 1, 0);
        send(0, 0, 0, 0, "restart_c0", 1, 0, 1, 0);
      end
      drive($urandom_range(0, 1), $urandom_range(0, CH - 1), $urandom_range(0, 1023) - 512,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 64),
            $urandom_range(0, 9) == 0);
      set_rdy($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0);
    set_rdy(1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
